// File: rtl/arf_stack_sequencer.sv
// arf_stack_sequencer: micro-sequences PC/AR/SP control and memory strobes for fetch, stack, jump, call/return and init.
module arf_stack_sequencer #(
    parameter int STACK_DEPTH = 16,
    localparam int DW = $clog2(STACK_DEPTH + 1)
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic [2:0]    Cmd,
    input  logic          CmdValid,
    output logic          CmdReady,
    output logic [2:0]    FunSel,
    output logic [2:0]    RegSel,
    output logic [1:0]    OutCSel,
    output logic [1:0]    OutDSel,
    output logic          ISel,
    output logic          MemRead,
    output logic          MemWrite,
    output logic          Done,
    output logic          Error,
    output logic [DW-1:0] Depth
);
    localparam logic [4:0] IDLE   = 5'd0;
    localparam logic [4:0] F_RD   = 5'd1;
    localparam logic [4:0] F_INC  = 5'd2;
    localparam logic [4:0] PU_DEC = 5'd3;
    localparam logic [4:0] PU_WR  = 5'd4;
    localparam logic [4:0] PO_RD  = 5'd5;
    localparam logic [4:0] PO_INC = 5'd6;
    localparam logic [4:0] J_LD   = 5'd7;
    localparam logic [4:0] C_DEC  = 5'd8;
    localparam logic [4:0] C_WR   = 5'd9;
    localparam logic [4:0] C_LD   = 5'd10;
    localparam logic [4:0] R_RD   = 5'd11;
    localparam logic [4:0] R_LD   = 5'd12;
    localparam logic [4:0] R_INC  = 5'd13;
    localparam logic [4:0] I_CLR  = 5'd14;
    localparam logic [4:0] I_LD   = 5'd15;
    localparam logic [4:0] NOP_ST = 5'd16;
    localparam logic [4:0] ERR_ST = 5'd17;

    logic [4:0]    state_q, state_d;
    logic [DW-1:0] depth_q, depth_d;
    logic          full, empty;

    assign full     = depth_q == DW'(STACK_DEPTH);
    assign empty    = depth_q == '0;
    assign CmdReady = state_q == IDLE;
    assign Depth    = depth_q;

    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE: begin
                state_d = IDLE;
                if (CmdValid)
                    case (Cmd)
                        3'b000:  state_d = NOP_ST;
                        3'b001:  state_d = F_RD;
                        3'b010:  state_d = full ? ERR_ST : PU_DEC;
                        3'b011:  state_d = empty ? ERR_ST : PO_RD;
                        3'b100:  state_d = J_LD;
                        3'b101:  state_d = full ? ERR_ST : C_DEC;
                        3'b110:  state_d = empty ? ERR_ST : R_RD;
                        default: state_d = I_CLR;
                    endcase
            end
            F_RD:    state_d = F_INC;
            PU_DEC:  state_d = PU_WR;
            PO_RD:   state_d = PO_INC;
            C_DEC:   state_d = C_WR;
            C_WR:    state_d = C_LD;
            R_RD:    state_d = R_LD;
            R_LD:    state_d = R_INC;
            I_CLR:   state_d = I_LD;
            default: state_d = IDLE;
        endcase
    end

    // Every non-idle state lasts one cycle, so state_d == X here means "entering X".
    assign depth_d = (state_d == I_LD) ? '0 :
                     ((state_d == PU_WR || state_d == C_WR) && !full) ? depth_q + 1'b1 :
                     ((state_d == PO_INC || state_d == R_INC) && !empty) ? depth_q - 1'b1 :
                     depth_q;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= IDLE;
            depth_q <= '0;
        end else begin
            state_q <= state_d;
            depth_q <= depth_d;
        end
    end

    always_comb begin
        RegSel   = 3'b111;
        FunSel   = 3'b000;
        OutCSel  = 2'b00;
        OutDSel  = 2'b00;
        ISel     = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        Done     = 1'b0;
        Error    = 1'b0;
        case (state_q)
            F_RD:   MemRead = 1'b1;
            F_INC:  begin RegSel = 3'b011; FunSel = 3'b001; Done = 1'b1; end
            PU_DEC: RegSel = 3'b110;
            PU_WR:  begin OutDSel = 2'b11; OutCSel = 2'b10; MemWrite = 1'b1; Done = 1'b1; end
            PO_RD:  begin OutDSel = 2'b11; MemRead = 1'b1; end
            PO_INC: begin RegSel = 3'b110; FunSel = 3'b001; Done = 1'b1; end
            J_LD:   begin RegSel = 3'b011; FunSel = 3'b010; Done = 1'b1; end
            C_DEC:  RegSel = 3'b110;
            C_WR:   begin OutDSel = 2'b11; MemWrite = 1'b1; end
            C_LD:   begin RegSel = 3'b011; FunSel = 3'b010; Done = 1'b1; end
            R_RD:   begin OutDSel = 2'b11; MemRead = 1'b1; end
            R_LD:   begin RegSel = 3'b011; FunSel = 3'b010; ISel = 1'b1; end
            R_INC:  begin RegSel = 3'b110; FunSel = 3'b001; Done = 1'b1; end
            I_CLR:  begin RegSel = 3'b001; FunSel = 3'b011; end
            I_LD:   begin RegSel = 3'b110; FunSel = 3'b010; Done = 1'b1; end
            NOP_ST: Done = 1'b1;
            ERR_ST: begin Done = 1'b1; Error = 1'b1; end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_arf_stack_sequencer.sv
// tb_arf_stack_sequencer: scoreboard bench with a behavioural ARF and memory driven by the sequencer outputs.
module tb_arf_stack_sequencer;
    localparam logic [2:0] NOP = 3'd0, FETCH = 3'd1, PUSH = 3'd2, POP = 3'd3;
    localparam logic [2:0] JUMP = 3'd4, CALL = 3'd5, RET = 3'd6, INIT = 3'd7;

    logic       Clock = 1'b0, Reset = 1'b1, CmdValid = 1'b0;
    logic [2:0] Cmd = 3'd0;
    logic       CmdReady, ISel, MemRead, MemWrite, Done, Error;
    logic [2:0] FunSel, RegSel;
    logic [1:0] OutCSel, OutDSel;
    logic [4:0] Depth;

    arf_stack_sequencer #(.STACK_DEPTH(16)) dut (
        .Clock(Clock), .Reset(Reset), .Cmd(Cmd), .CmdValid(CmdValid), .CmdReady(CmdReady),
        .FunSel(FunSel), .RegSel(RegSel), .OutCSel(OutCSel), .OutDSel(OutDSel), .ISel(ISel),
        .MemRead(MemRead), .MemWrite(MemWrite), .Done(Done), .Error(Error), .Depth(Depth)
    );

    always #5 Clock = ~Clock;

    int errors = 0, checks = 0;
    int md = 0;
    logic [19:0] sbq[$];

    // Environment: ARF registers, memory and data register reacting to the strobes.
    logic [15:0] pc = '0, ar = '0, sp = '0, mdr = '0, op = '0;
    logic [15:0] mem [0:65535];
    logic        preset = 1'b0;
    logic [15:0] pre_pc = '0, pre_ar = '0;
    logic [15:0] addr, outc, ival;

    function automatic logic [15:0] sel(input logic [1:0] s, input logic [15:0] p, a, q);
        return s == 2'b00 ? p : s == 2'b10 ? a : s == 2'b11 ? q : 16'h0;
    endfunction

    function automatic logic [15:0] alu(input logic [2:0] f, input logic [15:0] r, i);
        return f == 3'b000 ? r - 16'd1 : f == 3'b001 ? r + 16'd1 : f == 3'b010 ? i : f == 3'b011 ? 16'h0 : r;
    endfunction

    assign addr = sel(OutDSel, pc, ar, sp);
    assign outc = sel(OutCSel, pc, ar, sp);
    assign ival = ISel ? mdr : op;

    always @(posedge Clock) begin
        if (MemRead) mdr <= mem[addr];
        if (MemWrite) mem[addr] <= outc;
        if (preset) begin
            pc <= pre_pc;
            ar <= pre_ar;
        end else begin
            if (!RegSel[2]) pc <= alu(FunSel, pc, ival);
            if (!RegSel[1]) ar <= alu(FunSel, ar, ival);
        end
        if (!RegSel[0]) sp <= alu(FunSel, sp, ival);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [19:0] v(input int rs, fs, oc, od, is, mr, mw, dn, er, d);
        return {3'(rs), 3'(fs), 2'(oc), 2'(od), 1'(is), 1'(mr), 1'(mw), 1'(dn), 1'(er), 5'(d)};
    endfunction

    // Hand-written per-cycle output vectors for each command, from the accepting edge to Done.
    task automatic push_seq(input logic [2:0] c);
        if (((c == PUSH || c == CALL) && md == 16) || ((c == POP || c == RET) && md == 0)) begin
            sbq.push_back(v(7, 0, 0, 0, 0, 0, 0, 1, 1, md));
            return;
        end
        case (c)
            NOP:   sbq.push_back(v(7, 0, 0, 0, 0, 0, 0, 1, 0, md));
            FETCH: begin
                sbq.push_back(v(7, 0, 0, 0, 0, 1, 0, 0, 0, md));
                sbq.push_back(v(3, 1, 0, 0, 0, 0, 0, 1, 0, md));
            end
            PUSH: begin
                sbq.push_back(v(6, 0, 0, 0, 0, 0, 0, 0, 0, md));
                md++;
                sbq.push_back(v(7, 0, 2, 3, 0, 0, 1, 1, 0, md));
            end
            POP: begin
                sbq.push_back(v(7, 0, 0, 3, 0, 1, 0, 0, 0, md));
                md--;
                sbq.push_back(v(6, 1, 0, 0, 0, 0, 0, 1, 0, md));
            end
            JUMP:  sbq.push_back(v(3, 2, 0, 0, 0, 0, 0, 1, 0, md));
            CALL: begin
                sbq.push_back(v(6, 0, 0, 0, 0, 0, 0, 0, 0, md));
                md++;
                sbq.push_back(v(7, 0, 0, 3, 0, 0, 1, 0, 0, md));
                sbq.push_back(v(3, 2, 0, 0, 0, 0, 0, 1, 0, md));
            end
            RET: begin
                sbq.push_back(v(7, 0, 0, 3, 0, 1, 0, 0, 0, md));
                sbq.push_back(v(3, 2, 0, 0, 1, 0, 0, 0, 0, md));
                md--;
                sbq.push_back(v(6, 1, 0, 0, 0, 0, 0, 1, 0, md));
            end
            default: begin
                sbq.push_back(v(1, 3, 0, 0, 0, 0, 0, 0, 0, md));
                md = 0;
                sbq.push_back(v(6, 2, 0, 0, 0, 0, 0, 1, 0, md));
            end
        endcase
    endtask

    always @(negedge Clock) begin
        if (!Reset && !CmdReady) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL busy_unexpected: got busy cycle expected idle at %0t", $time);
            end else
                chk("seq", {RegSel, FunSel, OutCSel, OutDSel, ISel, MemRead, MemWrite, Done, Error, Depth},
                    32'(sbq.pop_front()));
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (!CmdReady && n < 20) begin
            @(negedge Clock);
            n++;
        end
        if (!CmdReady) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got CmdReady 0 expected 1 at %0t", $time);
        end
    endtask

    task automatic issue(input logic [2:0] c);
        wait_idle();
        Cmd = c;
        CmdValid = 1'b1;
        push_seq(c);
        @(negedge Clock);
        CmdValid = 1'b0;
    endtask

    task automatic set_regs(input logic [15:0] p, a);
        pre_pc = p;
        pre_ar = a;
        preset = 1'b1;
        @(negedge Clock);
        preset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge Clock);
        Reset = 1'b0;
        @(negedge Clock);
        chk("reset_ready", CmdReady, 1);
        chk("reset_regsel", RegSel, 3'b111);
        chk("reset_depth", Depth, 0);
        chk("reset_strobes", {MemRead, MemWrite, Done, Error}, 0);

        op = 16'h00FF;
        issue(INIT);
        wait_idle();
        chk("init_sp", sp, 16'h00FF);
        chk("init_pc", pc, 16'h0000);
        issue(FETCH);
        wait_idle();
        chk("fetch_pc", pc, 16'h0001);

        set_regs(16'h0001, 16'h1234);
        issue(PUSH);
        wait_idle();
        chk("push_sp", sp, 16'h00FE);
        chk("push_mem", mem[16'h00FE], 16'h1234);
        chk("push_depth", Depth, 1);
        issue(POP);
        wait_idle();
        chk("pop_sp", sp, 16'h00FF);
        chk("pop_mdr", mdr, 16'h1234);
        chk("pop_depth", Depth, 0);

        set_regs(16'h0010, 16'h1234);
        op = 16'h0400;
        issue(CALL);
        wait_idle();
        chk("call_mem", mem[16'h00FE], 16'h0010);
        chk("call_pc", pc, 16'h0400);
        chk("call_sp", sp, 16'h00FE);
        issue(RET);
        wait_idle();
        chk("ret_pc", pc, 16'h0010);
        chk("ret_sp", sp, 16'h00FF);

        // Reset while C_WR is on the outputs.
        issue(CALL);
        @(negedge Clock);
        chk("cwr_write", MemWrite, 1);
        #1 Reset = 1'b1;
        @(negedge Clock);
        chk("rst_mid_write", MemWrite, 0);
        chk("rst_mid_ready", CmdReady, 1);
        chk("rst_mid_regsel", RegSel, 3'b111);
        chk("rst_mid_depth", Depth, 0);
        Reset = 1'b0;
        sbq.delete();
        md = 0;
        @(negedge Clock);
        chk("rst_sp", sp, 16'h00FE);

        issue(POP);
        wait_idle();
        chk("pop_err_sp", sp, 16'h00FE);
        for (int i = 0; i < 17; i++) issue(PUSH);
        wait_idle();
        chk("full_depth", Depth, 16);
        chk("full_sp", sp, 16'h00EE);

        op = 16'h0123;
        Cmd = JUMP;
        CmdValid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("jump_ready", CmdReady, (i % 2 == 0) ? 1 : 0);
            if (i % 2 == 0) push_seq(JUMP);
            @(negedge Clock);
        end
        CmdValid = 1'b0;
        chk("jump_pc", pc, 16'h0123);

        issue(NOP);
        wait_idle();
        @(negedge Clock);
        chk("sb_empty", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/arf_stack_sequencer.md
# arf_stack_sequencer

Multi-cycle controller that drives the control inputs of the address register file (PC, AR, SP) and the memory strobes, so that instruction fetch, stack push/pop, jump, call/return and pointer initialisation run as fixed micro-sequences. It sits between the instruction decoder, which issues commands over a valid/ready handshake, and the address register file, whose `FunSel`/`RegSel`/`OutCSel`/`OutDSel` it owns exclusively. It also tracks stack occupancy and rejects overflowing or underflowing stack commands.

## Interface
- `STACK_DEPTH`, 16: maximum number of outstanding stack entries; the depth counter is `$clog2(STACK_DEPTH+1)` bits wide.
- `Clock` input 1: single clock; all state changes on the rising edge.
- `Reset` input 1: synchronous, active-high.
- `Cmd` input 3: 000 NOP, 001 FETCH, 010 PUSH, 011 POP, 100 JUMP, 101 CALL, 110 RET, 111 INIT.
- `CmdValid` input 1: decoder presents `Cmd`.
- `CmdReady` output 1: high only in IDLE.
- `FunSel` output 3: to ARF. 000 decrement, 001 increment, 010 load, 011 clear.
- `RegSel` output 3: to ARF, active-low enables, bit order {PC, AR, SP}. 111 = none.
- `OutCSel` output 2: to ARF. 00 PC, 10 AR, 11 SP.
- `OutDSel` output 2: to ARF (memory address bus). Same encoding as `OutCSel`.
- `ISel` output 1: ARF `I` mux. 0 = decoder operand, 1 = registered memory read data.
- `MemRead` output 1: memory read strobe.
- `MemWrite` output 1: memory write strobe; write data is ARF `OutC`.
- `Done` output 1: one-cycle pulse in the final state of a command.
- `Error` output 1: one-cycle pulse, coincident with `Done`, for a rejected command.
- `Depth` output `$clog2(STACK_DEPTH+1)`: current stack occupancy.

## Operation
- The FSM is Moore; all outputs decode from the registered state.
- Idle/default output values: `RegSel`=111, `FunSel`=000, `OutCSel`=00, `OutDSel`=00, `ISel`=0, `MemRead`/`MemWrite`/`Done`/`Error`=0.
- Accept: `CmdValid & CmdReady` at an edge latches `Cmd` and leaves IDLE. The next state is the first state of the command.
- Stack is full-descending with pre-decrement: SP points at the last written entry.
- State sequences (each state is one cycle; only the listed outputs differ from default):
  - FETCH: F_RD (`OutDSel`=00, `MemRead`) -> F_INC (`RegSel`=011, `FunSel`=001, `Done`).
  - PUSH: PU_DEC (`RegSel`=110, `FunSel`=000) -> PU_WR (`OutDSel`=11, `OutCSel`=10, `MemWrite`, `Done`). Pushes AR.
  - POP: PO_RD (`OutDSel`=11, `MemRead`) -> PO_INC (`RegSel`=110, `FunSel`=001, `Done`).
  - JUMP: J_LD (`RegSel`=011, `FunSel`=010, `ISel`=0, `Done`).
  - CALL: C_DEC (SP decrement) -> C_WR (`OutDSel`=11, `OutCSel`=00, `MemWrite`) -> C_LD (PC load, `ISel`=0, `Done`).
  - RET: R_RD (`OutDSel`=11, `MemRead`) -> R_LD (PC load, `ISel`=1) -> R_INC (SP increment, `Done`).
  - INIT: I_CLR (`RegSel`=001, `FunSel`=011; clears PC and AR) -> I_LD (`RegSel`=110, `FunSel`=010, `ISel`=0, `Done`).
  - NOP: NOP_ST (`Done`).
- Rejection: a PUSH or CALL accepted while `Depth`==`STACK_DEPTH`, or a POP or RET accepted while `Depth`==0, goes to ERR_ST. ERR_ST asserts `Done` and `Error`, with no register enables and no memory strobes.
- `Depth` update:
  - +1 on entering PU_WR or C_WR.
  - −1 on entering PO_INC or R_INC.
  - Cleared to 0 on entering I_LD.
  - Never wraps.
- Every final state returns to IDLE.

## Timing
- On `Reset`: state goes to IDLE, `Depth`=0, and all outputs take their default values on the next cycle. This includes a reset in the middle of a sequence: no further enables or strobes are issued. ARF contents are not touched.
- Latency from the accepting edge to the `Done` cycle:
  - 1 cycle for NOP, JUMP and ERR.
  - 2 cycles for FETCH, PUSH, POP and INIT.
  - 3 cycles for CALL and RET.
- `CmdReady` is 0 from the accepting edge until the cycle after `Done`. Minimum command spacing is therefore latency + 1 cycles.
- Memory read data must be valid at the edge ending R_RD and F_RD/PO_RD; the external data register captures it there.
- `CmdValid` while not ready is ignored. `Cmd` is sampled only at accept.

## Test plan
- Reset, then idle: `RegSel`=111, `CmdReady`=1, `Depth`=0, no strobes. Repeat with `Reset` asserted during C_WR: the next cycle is IDLE with `MemWrite`=0.
- INIT with operand 16'h00FF, then FETCH with PC=0: I_CLR shows `RegSel`=001 and `FunSel`=011. I_LD loads SP. FETCH reads address 0 via `OutDSel`=00, then PC becomes 1, with `Done` 2 cycles after accept.
- PUSH then POP with SP=16'h00FF, AR=16'h1234: the write goes to 16'h00FE with data 16'h1234 and `Depth`=1. POP reads 16'h00FE, SP returns to 16'h00FF, and `Depth`=0.
- CALL with operand 16'h0400 at PC=16'h0010, then RET with memory returning 16'h0010: memory[SP−1] receives 16'h0010 and PC becomes 16'h0400. RET restores PC to 16'h0010 and SP is restored, with 3-cycle latency each.
- POP at `Depth`=0 -> `Done`+`Error` 1 cycle after accept, no strobes, SP unchanged. Then 16 PUSHes followed by a 17th -> the 17th gives `Error`, and `Depth` stays at 16.
- CmdValid held high continuously with JUMP: accepts occur every 2 cycles, and `CmdReady` is low during each J_LD cycle.
